// File: rtl/reorder_buffer_pkg.sv
// Shared widths, sentinels, entry type encodings and the entry layout for the reorder buffer.
package reorder_buffer_pkg;

  localparam int unsigned ROB_WIDTH    = 4;
  localparam int unsigned ROB_SIZE     = 1 << ROB_WIDTH;
  localparam int unsigned EX_ROB_WIDTH = ROB_WIDTH + 1;
  localparam int unsigned EX_REG_WIDTH = 6;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned CNT_WIDTH    = ROB_WIDTH + 1;

  localparam logic [EX_ROB_WIDTH-1:0] NON_DEP = EX_ROB_WIDTH'(ROB_SIZE);
  localparam logic [EX_REG_WIDTH-1:0] NON_REG = EX_REG_WIDTH'(32);

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2
  } rob_type_e;

  typedef struct packed {
    logic                    busy;
    logic                    ready;
    rob_type_e               kind;
    logic [EX_REG_WIDTH-1:0] rd;
    logic [XLEN-1:0]         value;
    logic                    pred_taken;
    logic                    taken;
    logic [XLEN-1:0]         alt_pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_ring_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer ring; a flush empties the ring.
module rob_ring_ctrl
  import reorder_buffer_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 alloc,
  input  logic                 pop,
  input  logic                 flush,
  output logic [ROB_WIDTH-1:0] head,
  output logic [ROB_WIDTH-1:0] tail,
  output logic                 full
);

  logic [CNT_WIDTH-1:0] count;

  assign full = (count == CNT_WIDTH'(ROB_SIZE));

  // Pointers wrap naturally at ROB_SIZE; count disambiguates full from empty.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (alloc) tail <= tail + ROB_WIDTH'(1);
        if (pop)   head <= head + ROB_WIDTH'(1);
        case ({alloc, pop})
          2'b10:   count <= count + CNT_WIDTH'(1);
          2'b01:   count <= count - CNT_WIDTH'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit stage: allocates on dispatch, captures CDB results, retires one entry per cycle
// and flushes everything on a branch mispredict detected at commit.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    DP2ROB_en,
  input  logic [1:0]              DP2ROB_type,
  input  logic [EX_REG_WIDTH-1:0] DP2ROB_rd,
  input  logic                    DP2ROB_pred_taken,
  input  logic [XLEN-1:0]         DP2ROB_alt_pc,
  input  logic [EX_ROB_WIDTH-1:0] DP2ROB_Qj,
  input  logic [EX_ROB_WIDTH-1:0] DP2ROB_Qk,
  output logic                    ROB2DP_full,
  output logic [EX_ROB_WIDTH-1:0] ROB2DP_index,
  output logic                    ROB2DP_Qj_ready,
  output logic                    ROB2DP_Qk_ready,
  output logic [XLEN-1:0]         ROB2DP_Vj,
  output logic [XLEN-1:0]         ROB2DP_Vk,
  input  logic                    CDB_en,
  input  logic [ROB_WIDTH-1:0]    CDB_ROB_index,
  input  logic [XLEN-1:0]         CDB_value,
  input  logic                    CDB_taken,
  output logic                    ROB2RF_en,
  output logic [ROB_WIDTH-1:0]    ROB2RF_ROB_index,
  output logic [EX_REG_WIDTH-1:0] ROB2RF_rd,
  output logic [XLEN-1:0]         ROB2RF_value,
  output logic                    ROB2RF_pre_judge,
  output logic                    ROB2LSB_commit_en,
  output logic [ROB_WIDTH-1:0]    ROB2LSB_ROB_index,
  output logic                    ROB2IF_jump_en,
  output logic [XLEN-1:0]         ROB2IF_pc
);

  rob_entry_t           entries [ROB_SIZE];
  rob_entry_t           head_e;
  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;
  logic                 full;
  logic                 commit_c;
  logic                 mispredict_c;
  logic                 alloc_c;

  assign head_e       = entries[head];
  assign commit_c     = head_e.busy && head_e.ready;
  assign mispredict_c = commit_c && (head_e.kind == ROB_BRANCH) &&
                        (head_e.taken != head_e.pred_taken);
  assign alloc_c      = DP2ROB_en && !full && !mispredict_c;

  assign ROB2DP_full  = full;
  assign ROB2DP_index = {1'b0, tail};

  rob_ring_ctrl u_ring (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .alloc  (alloc_c),
    .pop    (commit_c),
    .flush  (mispredict_c),
    .head   (head),
    .tail   (tail),
    .full   (full)
  );

  // Operand lookup: the live CDB broadcast takes priority over the stored entry.
  function automatic logic [XLEN:0] query(input logic [EX_ROB_WIDTH-1:0] q);
    logic [ROB_WIDTH-1:0] idx;
    idx = q[ROB_WIDTH-1:0];
    if (q[ROB_WIDTH])                            query = '0;
    else if (CDB_en && (CDB_ROB_index == idx))   query = {1'b1, CDB_value};
    else                                         query = {entries[idx].ready, entries[idx].value};
  endfunction

  assign {ROB2DP_Qj_ready, ROB2DP_Vj} = query(DP2ROB_Qj);
  assign {ROB2DP_Qk_ready, ROB2DP_Vk} = query(DP2ROB_Qk);

  // Entry array; a mispredict drops any same-cycle allocation or writeback.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
    end else if (rdy_in) begin
      if (mispredict_c) begin
        for (int i = 0; i < ROB_SIZE; i++) entries[i].busy <= 1'b0;
      end else begin
        if (CDB_en && entries[CDB_ROB_index].busy) begin
          entries[CDB_ROB_index].ready <= 1'b1;
          entries[CDB_ROB_index].value <= CDB_value;
          entries[CDB_ROB_index].taken <= CDB_taken;
        end
        if (alloc_c) begin
          entries[tail] <= '{busy: 1'b1, ready: 1'b0, kind: rob_type_e'(DP2ROB_type),
                             rd: DP2ROB_rd, value: '0, pred_taken: DP2ROB_pred_taken,
                             taken: 1'b0, alt_pc: DP2ROB_alt_pc};
        end
        if (commit_c) entries[head].busy <= 1'b0;
      end
    end
  end

  // Registered commit strobes; data fields hold between commits.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ROB2RF_en         <= 1'b0;
      ROB2RF_ROB_index  <= '0;
      ROB2RF_rd         <= '0;
      ROB2RF_value      <= '0;
      ROB2RF_pre_judge  <= 1'b1;
      ROB2LSB_commit_en <= 1'b0;
      ROB2LSB_ROB_index <= '0;
      ROB2IF_jump_en    <= 1'b0;
      ROB2IF_pc         <= '0;
    end else if (rdy_in) begin
      ROB2RF_en         <= 1'b0;
      ROB2RF_pre_judge  <= 1'b1;
      ROB2LSB_commit_en <= 1'b0;
      ROB2IF_jump_en    <= 1'b0;
      if (commit_c) begin
        case (head_e.kind)
          ROB_REG: begin
            ROB2RF_en        <= 1'b1;
            ROB2RF_ROB_index <= head;
            ROB2RF_rd        <= head_e.rd;
            ROB2RF_value     <= head_e.value;
          end
          ROB_STORE: begin
            ROB2LSB_commit_en <= 1'b1;
            ROB2LSB_ROB_index <= head;
          end
          ROB_BRANCH: begin
            if (mispredict_c) begin
              ROB2RF_pre_judge <= 1'b0;
              ROB2IF_jump_en   <= 1'b1;
              ROB2IF_pc        <= head_e.alt_pc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, bypass, ordered commit, mispredict flush,
// stall hold, mid-operation reset and full/wrap behaviour.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic                    rdy_in;
  logic                    DP2ROB_en;
  logic [1:0]              DP2ROB_type;
  logic [EX_REG_WIDTH-1:0] DP2ROB_rd;
  logic                    DP2ROB_pred_taken;
  logic [XLEN-1:0]         DP2ROB_alt_pc;
  logic [EX_ROB_WIDTH-1:0] DP2ROB_Qj;
  logic [EX_ROB_WIDTH-1:0] DP2ROB_Qk;
  logic                    ROB2DP_full;
  logic [EX_ROB_WIDTH-1:0] ROB2DP_index;
  logic                    ROB2DP_Qj_ready;
  logic                    ROB2DP_Qk_ready;
  logic [XLEN-1:0]         ROB2DP_Vj;
  logic [XLEN-1:0]         ROB2DP_Vk;
  logic                    CDB_en;
  logic [ROB_WIDTH-1:0]    CDB_ROB_index;
  logic [XLEN-1:0]         CDB_value;
  logic                    CDB_taken;
  logic                    ROB2RF_en;
  logic [ROB_WIDTH-1:0]    ROB2RF_ROB_index;
  logic [EX_REG_WIDTH-1:0] ROB2RF_rd;
  logic [XLEN-1:0]         ROB2RF_value;
  logic                    ROB2RF_pre_judge;
  logic                    ROB2LSB_commit_en;
  logic [ROB_WIDTH-1:0]    ROB2LSB_ROB_index;
  logic                    ROB2IF_jump_en;
  logic [XLEN-1:0]         ROB2IF_pc;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk_in = ~clk_in;

  reorder_buffer dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .DP2ROB_en         (DP2ROB_en),
    .DP2ROB_type       (DP2ROB_type),
    .DP2ROB_rd         (DP2ROB_rd),
    .DP2ROB_pred_taken (DP2ROB_pred_taken),
    .DP2ROB_alt_pc     (DP2ROB_alt_pc),
    .DP2ROB_Qj         (DP2ROB_Qj),
    .DP2ROB_Qk         (DP2ROB_Qk),
    .ROB2DP_full       (ROB2DP_full),
    .ROB2DP_index      (ROB2DP_index),
    .ROB2DP_Qj_ready   (ROB2DP_Qj_ready),
    .ROB2DP_Qk_ready   (ROB2DP_Qk_ready),
    .ROB2DP_Vj         (ROB2DP_Vj),
    .ROB2DP_Vk         (ROB2DP_Vk),
    .CDB_en            (CDB_en),
    .CDB_ROB_index     (CDB_ROB_index),
    .CDB_value         (CDB_value),
    .CDB_taken         (CDB_taken),
    .ROB2RF_en         (ROB2RF_en),
    .ROB2RF_ROB_index  (ROB2RF_ROB_index),
    .ROB2RF_rd         (ROB2RF_rd),
    .ROB2RF_value      (ROB2RF_value),
    .ROB2RF_pre_judge  (ROB2RF_pre_judge),
    .ROB2LSB_commit_en (ROB2LSB_commit_en),
    .ROB2LSB_ROB_index (ROB2LSB_ROB_index),
    .ROB2IF_jump_en    (ROB2IF_jump_en),
    .ROB2IF_pc         (ROB2IF_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    DP2ROB_en         = 1'b0;
    DP2ROB_type       = 2'd0;
    DP2ROB_rd         = NON_REG;
    DP2ROB_pred_taken = 1'b0;
    DP2ROB_alt_pc     = '0;
    DP2ROB_Qj         = NON_DEP;
    DP2ROB_Qk         = NON_DEP;
    CDB_en            = 1'b0;
    CDB_ROB_index     = '0;
    CDB_value         = '0;
    CDB_taken         = 1'b0;
  endtask

  task automatic set_alloc(input logic [1:0] t, input logic [EX_REG_WIDTH-1:0] rd,
                           input logic pred, input logic [31:0] alt);
    DP2ROB_en         = 1'b1;
    DP2ROB_type       = t;
    DP2ROB_rd         = rd;
    DP2ROB_pred_taken = pred;
    DP2ROB_alt_pc     = alt;
  endtask

  task automatic set_cdb(input logic [3:0] idx, input logic [31:0] v, input logic tk);
    CDB_en        = 1'b1;
    CDB_ROB_index = idx;
    CDB_value     = v;
    CDB_taken     = tk;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    idle();
    tick();
    tick();
    rst_in = 1'b1;

    // Reset state
    check("rst_full", 32'(ROB2DP_full), 32'd0);
    check("rst_index", 32'(ROB2DP_index), 32'd0);
    check("rst_pre_judge", 32'(ROB2RF_pre_judge), 32'd1);
    check("rst_rf_en", 32'(ROB2RF_en), 32'd0);
    check("rst_lsb_en", 32'(ROB2LSB_commit_en), 32'd0);
    check("rst_jump_en", 32'(ROB2IF_jump_en), 32'd0);
    check("rst_qj_nondep", 32'(ROB2DP_Qj_ready), 32'd0);

    // Minimum-latency REG commit
    set_alloc(2'd0, 6'd5, 1'b0, 32'h0);
    tick();
    idle();
    set_cdb(4'd0, 32'h1234, 1'b0);
    tick();
    idle();
    check("lat_rf_en_n2", 32'(ROB2RF_en), 32'd0);
    tick();
    check("lat_rf_en_n3", 32'(ROB2RF_en), 32'd1);
    check("lat_rf_rd", 32'(ROB2RF_rd), 32'd5);
    check("lat_rf_value", ROB2RF_value, 32'h1234);
    check("lat_rf_idx", 32'(ROB2RF_ROB_index), 32'd0);
    tick();
    check("lat_rf_pulse", 32'(ROB2RF_en), 32'd0);
    check("lat_index_after", 32'(ROB2DP_index), 32'd1);

    // Allocate entries 1..3, then query with same-cycle CDB bypass
    for (int i = 1; i <= 3; i++) begin
      check("alloc_index", 32'(ROB2DP_index), 32'(i));
      set_alloc(2'd0, 6'(i), 1'b0, 32'h0);
      tick();
    end
    idle();
    DP2ROB_Qj = 5'd3;
    DP2ROB_Qk = 5'd2;
    set_cdb(4'd3, 32'hBEEF, 1'b0);
    #1;
    check("bypass_qj_ready", 32'(ROB2DP_Qj_ready), 32'd1);
    check("bypass_vj", ROB2DP_Vj, 32'hBEEF);
    check("bypass_qk_ready", 32'(ROB2DP_Qk_ready), 32'd0);
    tick();
    CDB_en = 1'b0;
    #1;
    check("stored_qj_ready", 32'(ROB2DP_Qj_ready), 32'd1);
    check("stored_vj", ROB2DP_Vj, 32'hBEEF);

    // Out-of-order writeback: entry 2 ready before head entry 1
    set_cdb(4'd2, 32'h22, 1'b0);
    tick();
    idle();
    tick();
    tick();
    check("ooo_no_commit", 32'(ROB2RF_en), 32'd0);
    set_cdb(4'd1, 32'h11, 1'b0);
    tick();
    idle();
    tick();
    check("ooo_c1_en", 32'(ROB2RF_en), 32'd1);
    check("ooo_c1_idx", 32'(ROB2RF_ROB_index), 32'd1);
    check("ooo_c1_val", ROB2RF_value, 32'h11);
    tick();
    check("ooo_c2_en", 32'(ROB2RF_en), 32'd1);
    check("ooo_c2_idx", 32'(ROB2RF_ROB_index), 32'd2);
    check("ooo_c2_val", ROB2RF_value, 32'h22);
    tick();
    check("ooo_c3_en", 32'(ROB2RF_en), 32'd1);
    check("ooo_c3_rd", 32'(ROB2RF_rd), 32'd3);
    check("ooo_c3_val", ROB2RF_value, 32'hBEEF);
    tick();
    check("ooo_done", 32'(ROB2RF_en), 32'd0);

    // Mispredicted branch at index 4; younger entries are squashed
    check("br_index", 32'(ROB2DP_index), 32'd4);
    set_alloc(2'd2, NON_REG, 1'b0, 32'h100);
    tick();
    set_alloc(2'd0, 6'd7, 1'b0, 32'h0);
    set_cdb(4'd4, 32'h0, 1'b1);
    tick();
    set_alloc(2'd1, NON_REG, 1'b0, 32'h0);
    set_cdb(4'd5, 32'h77, 1'b0);
    tick();
    idle();
    check("mis_pre_judge", 32'(ROB2RF_pre_judge), 32'd0);
    check("mis_jump_en", 32'(ROB2IF_jump_en), 32'd1);
    check("mis_pc", ROB2IF_pc, 32'h100);
    check("mis_index", 32'(ROB2DP_index), 32'd0);
    check("mis_full", 32'(ROB2DP_full), 32'd0);
    tick();
    check("mis_pre_judge_pulse", 32'(ROB2RF_pre_judge), 32'd1);
    check("mis_jump_pulse", 32'(ROB2IF_jump_en), 32'd0);
    tick();
    tick();
    check("mis_no_young_rf", 32'(ROB2RF_en), 32'd0);
    check("mis_no_young_lsb", 32'(ROB2LSB_commit_en), 32'd0);
    check("mis_index_hold", 32'(ROB2DP_index), 32'd0);

    // Store commit followed by a correctly predicted branch
    set_alloc(2'd1, NON_REG, 1'b0, 32'h0);
    tick();
    set_alloc(2'd2, NON_REG, 1'b1, 32'h200);
    set_cdb(4'd0, 32'h0, 1'b0);
    tick();
    idle();
    set_cdb(4'd1, 32'h0, 1'b1);
    tick();
    idle();
    check("st_lsb_en", 32'(ROB2LSB_commit_en), 32'd1);
    check("st_lsb_idx", 32'(ROB2LSB_ROB_index), 32'd0);
    check("st_rf_en", 32'(ROB2RF_en), 32'd0);
    tick();
    check("br_ok_lsb", 32'(ROB2LSB_commit_en), 32'd0);
    check("br_ok_jump", 32'(ROB2IF_jump_en), 32'd0);
    check("br_ok_pre_judge", 32'(ROB2RF_pre_judge), 32'd1);
    check("br_ok_index", 32'(ROB2DP_index), 32'd2);

    // Stall holds registered outputs and state
    set_alloc(2'd0, 6'd9, 1'b0, 32'h0);
    tick();
    idle();
    set_cdb(4'd2, 32'h99, 1'b0);
    tick();
    idle();
    tick();
    check("stall_pre_en", 32'(ROB2RF_en), 32'd1);
    check("stall_pre_val", ROB2RF_value, 32'h99);
    rdy_in = 1'b0;
    set_alloc(2'd0, 6'd10, 1'b0, 32'h0);
    tick();
    check("stall_hold_en", 32'(ROB2RF_en), 32'd1);
    check("stall_hold_index", 32'(ROB2DP_index), 32'd3);
    tick();
    check("stall_hold_en2", 32'(ROB2RF_en), 32'd1);
    rdy_in = 1'b1;
    idle();
    tick();
    check("stall_release_en", 32'(ROB2RF_en), 32'd0);
    check("stall_release_index", 32'(ROB2DP_index), 32'd3);

    // Reset in the cycle a commit would be decided
    set_alloc(2'd0, 6'd4, 1'b0, 32'h0);
    tick();
    idle();
    set_cdb(4'd3, 32'h44, 1'b0);
    tick();
    idle();
    rst_in = 1'b0;
    #1;
    check("midrst_index", 32'(ROB2DP_index), 32'd0);
    check("midrst_rf_en", 32'(ROB2RF_en), 32'd0);
    tick();
    rst_in = 1'b1;
    tick();
    check("midrst_no_commit", 32'(ROB2RF_en), 32'd0);

    // Fill all 16 entries, overflow attempt, then commit one and wrap
    for (int i = 0; i < 16; i++) begin
      check("fill_full_low", 32'(ROB2DP_full), 32'd0);
      set_alloc(2'd0, 6'(i + 10), 1'b0, 32'h0);
      tick();
    end
    check("fill_full", 32'(ROB2DP_full), 32'd1);
    check("fill_index_wrap", 32'(ROB2DP_index), 32'd0);
    set_alloc(2'd0, 6'd30, 1'b0, 32'h0);
    tick();
    idle();
    check("overflow_full", 32'(ROB2DP_full), 32'd1);
    check("overflow_index", 32'(ROB2DP_index), 32'd0);
    set_cdb(4'd0, 32'hA0, 1'b0);
    tick();
    idle();
    check("commit_full_still", 32'(ROB2DP_full), 32'd1);
    tick();
    check("commit_full_clear", 32'(ROB2DP_full), 32'd0);
    check("commit_rf_rd", 32'(ROB2RF_rd), 32'd10);
    check("commit_rf_val", ROB2RF_value, 32'hA0);
    check("wrap_index", 32'(ROB2DP_index), 32'd0);
    set_alloc(2'd0, 6'd31, 1'b0, 32'h0);
    tick();
    idle();
    check("wrap_refull", 32'(ROB2DP_full), 32'd1);
    check("wrap_index_next", 32'(ROB2DP_index), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
